// File: rtl/loop_ctx_addr_gen.sv
// Multi-context nested-loop iterator: walks a configured loop nest and emits
// iterator tuples plus a linear address over valid/ready, with context save/restore.
module loop_ctx_addr_gen #(
  parameter int NUM_LOOPS = 8,
  parameter int LOOP_ID_W = 3,
  parameter int CTX_ID_W  = 2,
  parameter int ITER_W    = 16,
  parameter int STRIDE_W  = 16,
  parameter int ADDR_W    = 32
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        cfg_loop_v,
  input  logic [CTX_ID_W-1:0]         cfg_ctx,
  input  logic [ITER_W-1:0]           cfg_loop_bound,
  input  logic [STRIDE_W-1:0]         cfg_loop_stride,
  input  logic                        cfg_base_v,
  input  logic [ADDR_W-1:0]           cfg_base,
  input  logic                        cfg_clear,
  output logic                        cfg_err,
  input  logic [CTX_ID_W-1:0]         ctx_sel,
  input  logic                        start,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_LOOPS*ITER_W-1:0] out_iters,
  output logic [ADDR_W-1:0]           out_addr,
  output logic                        out_last,
  output logic [CTX_ID_W-1:0]         active_ctx,
  output logic                        busy,
  output logic                        done
);

  localparam int NUM_CTX = 1 << CTX_ID_W;
  localparam int CNT_W   = LOOP_ID_W + 1;
  localparam int PROD_W  = ITER_W + STRIDE_W;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [CNT_W-1:0]    r_cnt    [NUM_CTX];
  logic [ITER_W-1:0]   r_bound  [NUM_CTX][NUM_LOOPS];
  logic [STRIDE_W-1:0] r_stride [NUM_CTX][NUM_LOOPS];
  logic [ADDR_W-1:0]   r_base   [NUM_CTX];
  logic [ITER_W-1:0]   r_saved  [NUM_CTX][NUM_LOOPS];

  logic [ITER_W-1:0]   r_wbound  [NUM_LOOPS];
  logic [STRIDE_W-1:0] r_wstride [NUM_LOOPS];
  logic [ADDR_W-1:0]   r_wbase;
  logic [ITER_W-1:0]   r_iter    [NUM_LOOPS];
  logic [CTX_ID_W-1:0] r_active_ctx;
  logic                r_cfg_err;

  logic [ITER_W-1:0]   w_iter_nxt [NUM_LOOPS];
  logic [ADDR_W-1:0]   w_addr;
  logic                w_last;
  logic                w_valid;
  logic                w_hs;
  logic                w_switch;
  logic                w_carry;

  function automatic logic [ADDR_W-1:0] addr_term(input logic [ITER_W-1:0]   iter,
                                                  input logic [STRIDE_W-1:0] stride);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(iter) * PROD_W'(stride);
    return ADDR_W'(prod);
  endfunction

  assign w_valid  = (r_state == S_RUN);
  assign w_hs     = w_valid && out_ready;
  // The final handshake wins over a pending switch; otherwise any ctx_sel change switches.
  assign w_switch = w_valid && !(w_hs && w_last) && (ctx_sel != r_active_ctx);

  always_comb begin
    w_addr = r_wbase;
    w_last = 1'b1;
    for (int l = 0; l < NUM_LOOPS; l++) begin
      w_addr = w_addr + addr_term(r_iter[l], r_wstride[l]);
      if (r_iter[l] != r_wbound[l]) w_last = 1'b0;
    end
  end

  // Odometer: innermost slot steps, slots at their bound wrap and carry outward.
  always_comb begin
    w_carry = 1'b1;
    for (int l = NUM_LOOPS - 1; l >= 0; l--) begin
      w_iter_nxt[l] = r_iter[l];
      if (w_carry) begin
        if (r_iter[l] == r_wbound[l]) begin
          w_iter_nxt[l] = '0;
        end else begin
          w_iter_nxt[l] = r_iter[l] + ITER_W'(1);
          w_carry       = 1'b0;
        end
      end
    end
  end

  always_comb begin
    out_iters = '0;
    for (int l = 0; l < NUM_LOOPS; l++) out_iters[l*ITER_W +: ITER_W] = r_iter[l];
  end

  assign out_valid  = w_valid;
  assign out_addr   = w_addr;
  assign out_last   = w_valid && w_last;
  assign active_ctx = r_active_ctx;
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign cfg_err    = r_cfg_err;

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = S_LOAD;
      S_LOAD: w_state_nxt = S_RUN;
      S_RUN: begin
        if (w_hs && w_last) w_state_nxt = S_DONE;
        else if (w_switch)  w_state_nxt = S_LOAD;
      end
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cfg_err    <= 1'b0;
      r_active_ctx <= '0;
      r_wbase      <= '0;
      for (int l = 0; l < NUM_LOOPS; l++) begin
        r_wbound[l]  <= '0;
        r_wstride[l] <= '0;
        r_iter[l]    <= '0;
      end
      for (int c = 0; c < NUM_CTX; c++) begin
        r_cnt[c]  <= '0;
        r_base[c] <= '0;
        for (int l = 0; l < NUM_LOOPS; l++) begin
          r_bound[c][l]  <= '0;
          r_stride[c][l] <= '0;
          r_saved[c][l]  <= '0;
        end
      end
    end else begin
      if (cfg_loop_v) begin
        if (r_cnt[cfg_ctx] == CNT_W'(NUM_LOOPS)) begin
          r_cfg_err <= 1'b1;
        end else begin
          r_bound[cfg_ctx][r_cnt[cfg_ctx][LOOP_ID_W-1:0]]  <= cfg_loop_bound;
          r_stride[cfg_ctx][r_cnt[cfg_ctx][LOOP_ID_W-1:0]] <= cfg_loop_stride;
          r_cnt[cfg_ctx] <= r_cnt[cfg_ctx] + CNT_W'(1);
        end
      end
      if (cfg_base_v) r_base[cfg_ctx] <= cfg_base;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_active_ctx <= ctx_sel;
            for (int l = 0; l < NUM_LOOPS; l++) begin
              r_iter[l]           <= '0;
              r_saved[ctx_sel][l] <= '0;
            end
          end
        end
        S_LOAD: begin
          r_wbase <= r_base[r_active_ctx];
          for (int l = 0; l < NUM_LOOPS; l++) begin
            r_wbound[l]  <= (CNT_W'(l) < r_cnt[r_active_ctx]) ? r_bound[r_active_ctx][l]  : '0;
            r_wstride[l] <= (CNT_W'(l) < r_cnt[r_active_ctx]) ? r_stride[r_active_ctx][l] : '0;
            r_iter[l]    <= r_saved[r_active_ctx][l];
          end
        end
        S_RUN: begin
          if (w_switch) begin
            r_active_ctx <= ctx_sel;
            for (int l = 0; l < NUM_LOOPS; l++)
              r_saved[r_active_ctx][l] <= w_hs ? w_iter_nxt[l] : r_iter[l];
          end
          if (w_hs) begin
            for (int l = 0; l < NUM_LOOPS; l++) r_iter[l] <= w_iter_nxt[l];
          end
        end
        S_DONE: begin
          for (int l = 0; l < NUM_LOOPS; l++) r_saved[r_active_ctx][l] <= '0;
        end
        default: ;
      endcase

      // Clear is applied last so it overrides same-cycle appends, base writes and saves.
      if (cfg_clear) begin
        r_cnt[cfg_ctx]  <= '0;
        r_base[cfg_ctx] <= '0;
        for (int l = 0; l < NUM_LOOPS; l++) begin
          r_bound[cfg_ctx][l]  <= '0;
          r_stride[cfg_ctx][l] <= '0;
          r_saved[cfg_ctx][l]  <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_loop_ctx_addr_gen.sv
// Directed bench for loop_ctx_addr_gen: table-driven walks plus hand sequences
// for context switching, overflow, empty/clear and mid-walk reset.
module tb_loop_ctx_addr_gen;

  localparam int NUM_LOOPS = 8;
  localparam int LOOP_ID_W = 3;
  localparam int CTX_ID_W  = 2;
  localparam int ITER_W    = 16;
  localparam int STRIDE_W  = 16;
  localparam int ADDR_W    = 32;

  logic                        clk = 1'b0;
  logic                        reset_n;
  logic                        cfg_loop_v;
  logic [CTX_ID_W-1:0]         cfg_ctx;
  logic [ITER_W-1:0]           cfg_loop_bound;
  logic [STRIDE_W-1:0]         cfg_loop_stride;
  logic                        cfg_base_v;
  logic [ADDR_W-1:0]           cfg_base;
  logic                        cfg_clear;
  logic                        cfg_err;
  logic [CTX_ID_W-1:0]         ctx_sel;
  logic                        start;
  logic                        out_valid;
  logic                        out_ready;
  logic [NUM_LOOPS*ITER_W-1:0] out_iters;
  logic [ADDR_W-1:0]           out_addr;
  logic                        out_last;
  logic [CTX_ID_W-1:0]         active_ctx;
  logic                        busy;
  logic                        done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  loop_ctx_addr_gen #(
    .NUM_LOOPS(NUM_LOOPS), .LOOP_ID_W(LOOP_ID_W), .CTX_ID_W(CTX_ID_W),
    .ITER_W(ITER_W), .STRIDE_W(STRIDE_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cfg_loop_v(cfg_loop_v), .cfg_ctx(cfg_ctx), .cfg_loop_bound(cfg_loop_bound),
    .cfg_loop_stride(cfg_loop_stride), .cfg_base_v(cfg_base_v), .cfg_base(cfg_base),
    .cfg_clear(cfg_clear), .cfg_err(cfg_err), .ctx_sel(ctx_sel), .start(start),
    .out_valid(out_valid), .out_ready(out_ready), .out_iters(out_iters),
    .out_addr(out_addr), .out_last(out_last), .active_ctx(active_ctx),
    .busy(busy), .done(done)
  );

  typedef struct {
    logic        rdy;
    logic        v;
    logic [31:0] addr;
    logic [15:0] i0;
    logic [15:0] i1;
    logic        last;
    logic        dn;
    logic        bsy;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic void add(input logic rdy, input logic v, input logic [31:0] addr,
                              input logic [15:0] i0, input logic [15:0] i1,
                              input logic last, input logic dn, input logic bsy);
    vec_t e;
    e.rdy = rdy; e.v = v; e.addr = addr; e.i0 = i0; e.i1 = i1;
    e.last = last; e.dn = dn; e.bsy = bsy;
    vecs.push_back(e);
  endfunction

  // Tail of every walk: the DONE cycle then the IDLE cycle.
  function automatic void add_tail();
    add(1'b0, 1'b0, 32'h0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b1);
    add(1'b0, 1'b0, 32'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic run_vecs(input string tag);
    foreach (vecs[i]) begin
      out_ready = vecs[i].rdy;
      chk($sformatf("%s[%0d].valid", tag, i), 32'(out_valid), 32'(vecs[i].v));
      if (vecs[i].v) begin
        chk($sformatf("%s[%0d].addr", tag, i), out_addr, vecs[i].addr);
        chk($sformatf("%s[%0d].iter0", tag, i), 32'(out_iters[15:0]), 32'(vecs[i].i0));
        chk($sformatf("%s[%0d].iter1", tag, i), 32'(out_iters[31:16]), 32'(vecs[i].i1));
        chk($sformatf("%s[%0d].last", tag, i), 32'(out_last), 32'(vecs[i].last));
      end
      chk($sformatf("%s[%0d].done", tag, i), 32'(done), 32'(vecs[i].dn));
      chk($sformatf("%s[%0d].busy", tag, i), 32'(busy), 32'(vecs[i].bsy));
      tick();
    end
    vecs.delete();
    out_ready = 1'b0;
  endtask

  task automatic cfg_loop(input int ctx, input int bnd, input int strd);
    cfg_ctx = CTX_ID_W'(ctx); cfg_loop_bound = ITER_W'(bnd); cfg_loop_stride = STRIDE_W'(strd);
    cfg_loop_v = 1'b1;
    tick();
    cfg_loop_v = 1'b0;
  endtask

  task automatic cfg_base_w(input int ctx, input int b);
    cfg_ctx = CTX_ID_W'(ctx); cfg_base = ADDR_W'(b); cfg_base_v = 1'b1;
    tick();
    cfg_base_v = 1'b0;
  endtask

  // Leaves the DUT in its first RUN cycle.
  task automatic start_walk(input int ctx, input string tag);
    ctx_sel = CTX_ID_W'(ctx);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, ".load_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".load_busy"}, 32'(busy), 32'd1);
    tick();
  endtask

  initial begin
    reset_n = 1'b0; cfg_loop_v = 1'b0; cfg_ctx = '0; cfg_loop_bound = '0; cfg_loop_stride = '0;
    cfg_base_v = 1'b0; cfg_base = '0; cfg_clear = 1'b0; ctx_sel = '0; start = 1'b0;
    out_ready = 1'b0;
    tick(); tick();
    chk("rst.valid", 32'(out_valid), 32'd0);
    chk("rst.iters", 32'(|out_iters), 32'd0);
    chk("rst.addr", out_addr, 32'd0);
    chk("rst.last", 32'(out_last), 32'd0);
    chk("rst.active", 32'(active_ctx), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.err", 32'(cfg_err), 32'd0);
    reset_n = 1'b1;
    tick();

    cfg_base_w(0, 100);
    cfg_loop(0, 1, 10);
    cfg_loop(0, 2, 1);
    cfg_base_w(1, 0);
    cfg_loop(1, 3, 4);

    // Basic nest, full throughput.
    start_walk(0, "basic");
    add(1, 1, 100, 0, 0, 0, 0, 1);
    add(1, 1, 101, 0, 1, 0, 0, 1);
    add(1, 1, 102, 0, 2, 0, 0, 1);
    add(1, 1, 110, 1, 0, 0, 0, 1);
    add(1, 1, 111, 1, 1, 0, 0, 1);
    add(1, 1, 112, 1, 2, 1, 0, 1);
    add_tail();
    run_vecs("basic");

    // Backpressure: stalled tuples must hold.
    start_walk(0, "bp");
    add(1, 1, 100, 0, 0, 0, 0, 1);
    add(0, 1, 101, 0, 1, 0, 0, 1);
    add(0, 1, 101, 0, 1, 0, 0, 1);
    add(1, 1, 101, 0, 1, 0, 0, 1);
    add(0, 1, 102, 0, 2, 0, 0, 1);
    add(1, 1, 102, 0, 2, 0, 0, 1);
    add(1, 1, 110, 1, 0, 0, 0, 1);
    add(0, 1, 111, 1, 1, 0, 0, 1);
    add(1, 1, 111, 1, 1, 0, 0, 1);
    add(1, 1, 112, 1, 2, 1, 0, 1);
    add_tail();
    run_vecs("bp");

    // Context switch ctx0 -> ctx1 after 100 and 101 are accepted.
    start_walk(0, "sw");
    out_ready = 1'b1;
    chk("sw.a100", out_addr, 32'd100); tick();
    chk("sw.a101", out_addr, 32'd101); tick();
    chk("sw.a102", out_addr, 32'd102);
    ctx_sel = 2'd1; out_ready = 1'b0;
    tick();
    chk("sw.bubble_valid", 32'(out_valid), 32'd0);
    chk("sw.bubble_active", 32'(active_ctx), 32'd1);
    tick();
    add(1, 1, 0, 0, 0, 0, 0, 1);
    add(1, 1, 4, 1, 0, 0, 0, 1);
    add(1, 1, 8, 2, 0, 0, 0, 1);
    add(1, 1, 12, 3, 0, 1, 0, 1);
    add_tail();
    run_vecs("ctx1");

    // Start on ctx0 restarts from zero.
    start_walk(0, "restart");
    chk("restart.addr", out_addr, 32'd100);
    out_ready = 1'b1;
    tick(); tick();
    ctx_sel = 2'd1; out_ready = 1'b0;
    tick();
    chk("sw2.bubble_valid", 32'(out_valid), 32'd0);
    tick();
    chk("sw2.ctx1_addr0", out_addr, 32'd0);
    out_ready = 1'b1;
    tick();
    chk("sw2.ctx1_addr4", out_addr, 32'd4);
    ctx_sel = 2'd0; out_ready = 1'b0;
    tick();
    chk("sw2.back_valid", 32'(out_valid), 32'd0);
    chk("sw2.back_active", 32'(active_ctx), 32'd0);
    tick();
    add(1, 1, 102, 0, 2, 0, 0, 1);
    add(1, 1, 110, 1, 0, 0, 0, 1);
    add(1, 1, 111, 1, 1, 0, 0, 1);
    add(1, 1, 112, 1, 2, 1, 0, 1);
    add_tail();
    run_vecs("resume");

    // Overflow on ctx2: slot0 bound1 stride1000, slots1..6 empty, slot7 bound1 stride5.
    cfg_base_w(2, 0);
    cfg_loop(2, 1, 1000);
    for (int k = 0; k < 6; k++) cfg_loop(2, 0, 0);
    cfg_loop(2, 1, 5);
    chk("ovf.err_before", 32'(cfg_err), 32'd0);
    cfg_loop(2, 1, 100);
    chk("ovf.err_after", 32'(cfg_err), 32'd1);
    start_walk(2, "ovf");
    add(1, 1, 0, 0, 0, 0, 0, 1);
    add(1, 1, 5, 0, 0, 0, 0, 1);
    add(1, 1, 1000, 1, 0, 0, 0, 1);
    add(1, 1, 1005, 1, 0, 1, 0, 1);
    add_tail();
    run_vecs("ovf");
    chk("ovf.err_sticky", 32'(cfg_err), 32'd1);

    // Empty context emits a single tuple at its base.
    cfg_base_w(3, 'h40);
    start_walk(3, "empty");
    add(1, 1, 'h40, 0, 0, 1, 0, 1);
    add_tail();
    run_vecs("empty");

    // Clear with a same-cycle append: append dropped, base cleared.
    cfg_ctx = 2'd3; cfg_loop_bound = 16'd5; cfg_loop_stride = 16'd7;
    cfg_clear = 1'b1; cfg_loop_v = 1'b1;
    tick();
    cfg_clear = 1'b0; cfg_loop_v = 1'b0;
    start_walk(3, "clear");
    add(1, 1, 0, 0, 0, 1, 0, 1);
    add_tail();
    run_vecs("clear");

    // Mid-walk reset.
    start_walk(0, "mrst");
    out_ready = 1'b1;
    tick();
    chk("mrst.pre_addr", out_addr, 32'd101);
    reset_n = 1'b0;
    tick();
    chk("mrst.valid", 32'(out_valid), 32'd0);
    chk("mrst.busy", 32'(busy), 32'd0);
    chk("mrst.err", 32'(cfg_err), 32'd0);
    chk("mrst.done", 32'(done), 32'd0);
    chk("mrst.addr", out_addr, 32'd0);
    reset_n = 1'b1;
    out_ready = 1'b0;
    start_walk(0, "post");
    add(1, 1, 0, 0, 0, 1, 0, 1);
    add_tail();
    run_vecs("post");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/loop_ctx_addr_gen.md
# loop_ctx_addr_gen

Multi-context nested-loop iterator with address generation; successor to the single-output group loop controller in the systolic-array control path. Holds per-context loop bounds, strides and a base address, then walks the configured loop nest. For each iteration tuple it emits the iterators and a linear address `base + Σ iter*stride` over a valid/ready handshake. Contexts can be switched mid-walk with save/restore of progress, and the block reports configuration overflow.

## Interface
- `NUM_LOOPS`, 8: loop slots per context; slot 0 is outermost.
- `LOOP_ID_W`, 3: width of loop slot index, `$clog2(NUM_LOOPS)`.
- `CTX_ID_W`, 2: context id width; `NUM_CTX = 1 << CTX_ID_W`.
- `ITER_W`, 16: iterator/bound width.
- `STRIDE_W`, 16: unsigned stride width.
- `ADDR_W`, 32: address/base width.

- `clk` in 1: the block's single clock.
- `reset_n` in 1: synchronous, active-low reset.
- `cfg_loop_v` in 1: append a loop to context `cfg_ctx`.
- `cfg_ctx` in CTX_ID_W: target context of every cfg operation.
- `cfg_loop_bound` in ITER_W: last index of the loop (trip count − 1).
- `cfg_loop_stride` in STRIDE_W: address stride of the loop.
- `cfg_base_v` in 1: write base address of `cfg_ctx`.
- `cfg_base` in ADDR_W: base address.
- `cfg_clear` in 1: clear all loops, the base and the saved iterators of `cfg_ctx`.
- `cfg_err` out 1: sticky; set on an append to a full context; cleared by reset only.
- `ctx_sel` in CTX_ID_W: context to run/resume.
- `start` in 1: begin a walk of `ctx_sel` from zero; honoured in IDLE only.
- `out_valid` out 1: tuple valid.
- `out_ready` in 1: consumer accepts the tuple.
- `out_iters` out NUM_LOOPS*ITER_W: iterators; slot l at `[l*ITER_W +: ITER_W]`.
- `out_addr` out ADDR_W: linear address of the tuple.
- `out_last` out 1: the tuple is the final one of the nest.
- `active_ctx` out CTX_ID_W: context currently loaded.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle pulse after the last tuple is accepted.

## Operation
- Per-context tables: `cnt[c]` (0..NUM_LOOPS), `bound[c][l]`, `stride[c][l]`, `base[c]`, `saved_iters[c][l]`. Slots at or above `cnt[c]` act as bound 0, stride 0.
- Append rules:
  - `cfg_loop_v` writes slot `cnt[cfg_ctx]` and increments the count.
  - If `cnt == NUM_LOOPS`, the write is dropped and `cfg_err` is set.
  - `cfg_clear` together with `cfg_loop_v`/`cfg_base_v` on the same context: clear wins, and the writes are dropped.
- Configuration is snapshotted into working registers at LOAD. Later cfg writes do not affect the running walk.
- States:
  - IDLE: `start` → LOAD with `active_ctx <= ctx_sel`; working iterators are zeroed; `saved_iters[ctx_sel]` is zeroed.
  - LOAD (1 cycle): copy bounds, strides and base of `active_ctx` into working registers; restore iterators from `saved_iters[active_ctx]` (zero on start). Go to RUN.
  - RUN: `out_valid=1`. On handshake, iterators advance as an odometer: the innermost slot (NUM_LOOPS−1) increments; a slot at its bound wraps to 0 and carries outward.
    - Handshake while `out_last=1`: go to DONE.
    - `ctx_sel != active_ctx` at a clock edge: save working iterators (post-advance if a handshake occurred that cycle) into `saved_iters[active_ctx]`; `active_ctx <= ctx_sel`; go to LOAD.
    - A context switch takes priority over the last handshake only if no handshake occurred that cycle.
  - DONE (1 cycle): `done=1`; clear `saved_iters[active_ctx]`; go to IDLE.
- `start` outside IDLE is ignored. `ctx_sel` changes in IDLE, LOAD or DONE take effect only at the next `start`/RUN check.
- A context that was never started or already completed resumes from zero on switch-in.
- `out_last` = every slot's iterator equals its bound. A context with zero loops emits exactly one tuple with `out_addr = base` and `out_last = 1`.
- Address arithmetic:
  - Combinational from working registers: `base + Σ_l iter[l]*stride[l]`.
  - Each product is ITER_W+STRIDE_W bits; the sum is unsigned and truncated modulo 2^ADDR_W (wrap, no flag).
- Output stability: while `out_valid=1 && out_ready=0`, `out_iters`, `out_addr` and `out_last` hold stable.

## Timing
- Reset (`reset_n=0` at an edge): state IDLE. All outputs 0: `out_valid`, `out_iters`, `out_addr`, `out_last`, `active_ctx`, `busy`, `done`, `cfg_err`. All table entries and counts cleared. Mid-walk reset abandons the walk with no `done`.
- `start` sampled at edge k → LOAD in cycle k+1 → `out_valid` from cycle k+2.
- Throughput: one tuple per cycle under `out_ready=1`.
- Context switch costs exactly one bubble (LOAD) cycle with `out_valid=0`.
- `done` is high in the cycle after the last handshake. `busy` drops the cycle after that. A new `start` is accepted in that IDLE cycle.
- A cfg write at edge k is visible to a LOAD at k+1 or later.

## Test plan
- Basic nest: ctx0 with base 100, slot0 bound 1 stride 10, slot1 bound 2 stride 1; `out_ready=1`; start → addresses 100, 101, 102, 110, 111, 112 on consecutive cycles from start+2; `out_last` only on 112; `done` pulses at the next cycle.
- Backpressure: same config with `out_ready` pattern 1,0,0,1,0,1,… → identical address sequence; outputs stable during every stall cycle; no tuple duplicated or skipped.
- Context switch: ctx1 with base 0, one loop bound 3 stride 4. After ctx0 accepts 100 and 101, set `ctx_sel=1` → one bubble, then 0, 4, 8, 12 with `done`. Then `ctx_sel=0`, start → ctx0 restarts at 100. Repeat with the switch-back during ctx1's walk → ctx0 resumes at 102.
- Overflow: 9 appends to ctx2 with NUM_LOOPS=8 → `cfg_err=1`; the 9th loop is ignored; the walk covers 8 slots only.
- Empty context and clear: start on an unconfigured ctx3 with base 0x40 → single tuple 0x40 with `out_last=1`, then `done`. `cfg_clear` together with `cfg_loop_v` on ctx3 → cnt stays 0.
- Reset mid-walk: assert `reset_n=0` for one cycle during RUN → next cycle `out_valid=0`, `busy=0`, `cfg_err=0`, `done=0`; a subsequent start on ctx0 emits one tuple, addr 0.
